// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise-AND unit between N_REQ requesters.
// IDLE grants and captures operands, CAPT computes, RESP holds the result until taken.
module and_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy,
    output logic [15:0]            op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CAPT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDW-1:0]   idx;
    logic [IDW-1:0]   win_id;
    logic             win_found;

    // Search starts at ptr and wraps; first valid requester wins. Gated by rst_n so
    // no grant is shown while reset is held.
    always_comb begin
        req_ready = '0;
        win_id    = '0;
        win_found = 1'b0;
        idx       = '0;
        if (rst_n && state == IDLE) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                idx = IDW'((32'(ptr) + k) % N_REQ);
                if (!win_found && req_valid[idx]) begin
                    win_found = 1'b1;
                    win_id    = idx;
                end
            end
        end
        if (win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            id_q     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_a  <= req_a[win_id*WIDTH +: WIDTH];
                        op_b  <= req_b[win_id*WIDTH +: WIDTH];
                        id_q  <= win_id;
                        ptr   <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    rsp_data <= op_a & op_b;
                    rsp_id   <= id_q;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter: a cycle model plus a scoreboard of expected
// responses, checked with immediate assertions every cycle and at key points.
module tb_and_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;
    logic [15:0]    op_count;

    and_unit_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] data;
    } exp_t;

    exp_t        sb[$];
    int          gl[$];
    int          al[$];
    int          rem[N];
    int          n_vec = 0;
    int          n_mis = 0;
    int          ncyc  = 0;
    int          m_state = 0;
    int          m_ptr   = 0;
    logic [15:0] m_count = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_count = '0;
        sb.delete();
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        rem[i]          = n;
        req_valid[i]    = 1'b1;
    endtask

    // One clock: check outputs against the model at negedge, advance the model,
    // then let the accepted requester reload or drop just after posedge.
    task automatic cyc();
        logic [N-1:0] er;
        int           w;
        int           acc;
        exp_t         e;
        @(negedge clk);
        er  = '0;
        w   = -1;
        acc = -1;
        if (rst_n && m_state == 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && req_valid[j]) w = j;
            end
            if (w >= 0) er[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(er));
        check("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
        check("busy", 32'(busy), 32'(m_state != 0));
        check("op_count", 32'(op_count), 32'(m_count));
        if (m_state == 2) begin
            if (sb.size() > 0) begin
                check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            end else begin
                check("sb_size", sb.size(), 1);
            end
        end
        if (rst_n) begin
            case (m_state)
                0: if (w >= 0) begin
                    e.id   = 2'(w);
                    e.data = req_a[w*W +: W] & req_b[w*W +: W];
                    sb.push_back(e);
                    gl.push_back(w);
                    al.push_back(ncyc);
                    m_ptr   = (w + 1) % N;
                    m_state = 1;
                    acc     = w;
                end
                1: m_state = 2;
                default: if (rsp_ready) begin
                    void'(sb.pop_front());
                    m_count = m_count + 16'd1;
                    m_state = 0;
                end
            endcase
        end
        @(posedge clk);
        ncyc++;
        #1;
        if (acc >= 0) begin
            rem[acc]--;
            if (rem[acc] > 0) begin
                req_a[acc*W +: W] = W'($urandom);
                req_b[acc*W +: W] = W'($urandom);
            end else begin
                req_valid[acc] = 1'b0;
            end
        end
    endtask

    task automatic drain(input int limit);
        for (int c = 0; c < limit && (req_valid != '0 || m_state != 0); c++) cyc();
        check("drain", {28'(req_valid), 4'(m_state)}, 32'd0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = 0;
        model_reset();

        // Reset values, with requests present to show no grant during reset
        req_valid = '1;
        cyc();
        cyc();
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // Single request from requester 2
        issue(2, 8'hF0, 8'h3C, 1);
        #1;
        check("b_grant", 32'(req_ready), 32'b0100);
        cyc();
        check("b_capt_valid", 32'(rsp_valid), 32'd0);
        check("b_capt_busy", 32'(busy), 32'd1);
        cyc();
        check("b_resp_valid", 32'(rsp_valid), 32'd1);
        check("b_resp_data", 32'(rsp_data), 32'h30);
        check("b_resp_id", 32'(rsp_id), 32'd2);
        cyc();
        check("b_count", 32'(op_count), 32'd1);

        // Contention from ptr 0: all four valid, two ops each
        reset_pulse();
        base = gl.size();
        for (int i = 0; i < N; i++) issue(i, W'($urandom), W'($urandom), 2);
        drain(60);
        check("c_grants", gl.size() - base, 8);
        if (gl.size() >= base + 8) begin
            for (int k = 0; k < 8; k++) check("c_order", gl[base+k], k % 4);
            for (int k = 0; k < 7; k++) check("c_spacing", al[base+k+1] - al[base+k], 3);
        end

        // Fairness skip: put ptr at 2, then 1 and 3 together
        issue(1, 8'h12, 8'h34, 1);
        drain(10);
        base = gl.size();
        issue(1, 8'hAA, 8'h0F, 1);
        issue(3, 8'h5C, 8'hC5, 1);
        drain(20);
        check("d_grants", gl.size() - base, 2);
        if (gl.size() >= base + 2) begin
            check("d_first", gl[base], 3);
            check("d_second", gl[base+1], 1);
        end

        // Back-pressure: requester 0 keeps a second op pending
        rsp_ready = 1'b0;
        issue(0, 8'hC3, 8'h5E, 2);
        for (int c = 0; c < 10 && !rsp_valid; c++) cyc();
        check("e_valid", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            cyc();
            check("e_hold_valid", 32'(rsp_valid), 32'd1);
            check("e_hold_data", 32'(rsp_data), 32'h42);
            check("e_hold_id", 32'(rsp_id), 32'd0);
            check("e_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cyc();
        check("e_regrant", 32'(req_ready), 32'b0001);
        drain(20);

        // Reset during CAPT discards the request and clears ptr
        issue(2, 8'h77, 8'h3F, 1);
        cyc();
        check("f_capt_busy", 32'(busy), 32'd1);
        reset_pulse();
        check("f_count", 32'(op_count), 32'd0);
        for (int c = 0; c < 4; c++) cyc();
        issue(1, 8'h81, 8'hFF, 1);
        issue(3, 8'h18, 8'hFF, 1);
        #1;
        check("f_grant_low", 32'(req_ready), 32'b0010);
        drain(20);

        // Counter wrap from 0xFFFE, with all-zero and all-one results
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        m_count = 16'hFFFE;
        issue(0, 8'hFF, 8'h00, 1);
        cyc();
        cyc();
        check("g_zero_data", 32'(rsp_data), 32'h00);
        cyc();
        check("g_count_ffff", 32'(op_count), 32'hFFFF);
        issue(0, 8'hFF, 8'hFF, 1);
        drain(20);
        check("g_wrap", 32'(op_count), 32'h0000);
        issue(3, 8'h55, 8'h0F, 1);
        cyc();
        cyc();
        check("g_ones_prev", 32'(rsp_data), 32'h05);
        cyc();
        check("g_count_1", 32'(op_count), 32'd1);
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
